// File: rtl/or1200_if_fetchq.sv
// Instruction-fetch queue between genpc and decode: one bus cycle per accepted
// address, responses buffered in-order as {pc, insn, err} in a small FIFO.
module or1200_if_fetchq #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] genpc_pc,
  input  logic        genpc_valid,
  output logic        genpc_ready,
  input  logic        flush,
  output logic [31:0] icpu_adr_o,
  output logic        icpu_cycstb_o,
  input  logic        icpu_ack_i,
  input  logic        icpu_err_i,
  input  logic [31:0] icpu_dat_i,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_insn,
  output logic [31:0] if_pc,
  output logic        if_err,
  output logic [2:0]  if_count
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam logic [31:0] NopInsn = 32'h1500_0000;

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e            state_q, state_d;
  logic [31:0]       adr_q, adr_d;
  logic              cyc_q, cyc_d;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [2:0]        count_q, count_d;
  logic [31:0]       mem_pc   [DEPTH];
  logic [31:0]       mem_insn [DEPTH];
  logic              mem_err  [DEPTH];

  logic        inflight, pop, resp, room, accept, push;
  logic [3:0]  occ;

  assign inflight = (state_q == StReq);
  assign resp     = icpu_ack_i | icpu_err_i;
  assign pop      = if_valid & id_ready & ~flush;
  // Occupancy including the slot reserved by the live request.
  assign occ      = {1'b0, count_q} + {3'b000, inflight} - {3'b000, pop};
  assign room     = occ < 4'(DEPTH);

  assign genpc_ready = rst & ~flush & room & ((state_q == StIdle) | (inflight & resp));
  assign accept      = genpc_valid & genpc_ready;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cyc_d   = cyc_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StReq;
          adr_d   = genpc_pc & 32'hFFFF_FFFC;
          cyc_d   = 1'b1;
        end
      end
      StReq: begin
        if (flush) begin
          if (resp) begin
            state_d = StIdle;
            cyc_d   = 1'b0;
          end else begin
            state_d = StDrain;
          end
        end else if (resp) begin
          push = 1'b1;
          if (accept) begin
            adr_d = genpc_pc & 32'hFFFF_FFFC;
          end else begin
            state_d = StIdle;
            cyc_d   = 1'b0;
          end
        end
      end
      StDrain: begin
        // The bus cannot abort a cycle; wait it out and discard the data.
        if (resp) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      adr_q   <= 32'h0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cyc_q   <= cyc_d;
    end
  end

  assign count_d = flush ? 3'd0 : (count_q + 3'(push) - 3'(pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= 3'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_pc[i]   <= 32'h0;
        mem_insn[i] <= 32'h0;
        mem_err[i]  <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_pc[wr_ptr_q]   <= adr_q;
          mem_insn[wr_ptr_q] <= icpu_err_i ? NopInsn : icpu_dat_i;
          mem_err[wr_ptr_q]  <= icpu_err_i;
          wr_ptr_q           <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
      end
    end
  end

  assign icpu_adr_o    = adr_q;
  assign icpu_cycstb_o = cyc_q;
  assign if_valid      = (count_q != 3'd0);
  assign if_insn       = mem_insn[rd_ptr_q];
  assign if_pc         = mem_pc[rd_ptr_q];
  assign if_err        = mem_err[rd_ptr_q];
  assign if_count      = count_q;

endmodule

// File: tb/tb_or1200_if_fetchq.sv
// Bench for or1200_if_fetchq: table-driven and directed checks on a DEPTH=2
// instance, wrap-around and random traffic against a queue model on DEPTH=4.
module tb_or1200_if_fetchq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // DEPTH = 2 instance
  logic [31:0] d2_pc, d2_adr, d2_dat, d2_insn, d2_ipc;
  logic        d2_v, d2_rdy, d2_fl, d2_cyc, d2_ack, d2_err, d2_idr, d2_val, d2_ierr;
  logic [2:0]  d2_cnt;

  or1200_if_fetchq #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .genpc_pc(d2_pc), .genpc_valid(d2_v), .genpc_ready(d2_rdy),
    .flush(d2_fl), .icpu_adr_o(d2_adr), .icpu_cycstb_o(d2_cyc), .icpu_ack_i(d2_ack),
    .icpu_err_i(d2_err), .icpu_dat_i(d2_dat), .id_ready(d2_idr), .if_valid(d2_val),
    .if_insn(d2_insn), .if_pc(d2_ipc), .if_err(d2_ierr), .if_count(d2_cnt)
  );

  // DEPTH = 4 instance
  logic [31:0] d4_pc, d4_adr, d4_dat, d4_insn, d4_ipc;
  logic        d4_v, d4_rdy, d4_fl, d4_cyc, d4_ack, d4_err, d4_idr, d4_val, d4_ierr;
  logic [2:0]  d4_cnt;

  or1200_if_fetchq #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .genpc_pc(d4_pc), .genpc_valid(d4_v), .genpc_ready(d4_rdy),
    .flush(d4_fl), .icpu_adr_o(d4_adr), .icpu_cycstb_o(d4_cyc), .icpu_ack_i(d4_ack),
    .icpu_err_i(d4_err), .icpu_dat_i(d4_dat), .id_ready(d4_idr), .if_valid(d4_val),
    .if_insn(d4_insn), .if_pc(d4_ipc), .if_err(d4_ierr), .if_count(d4_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic d2_drive(input logic v, input logic [31:0] pc, input logic ack,
                          input logic err, input logic [31:0] dat, input logic idr,
                          input logic fl);
    d2_v = v; d2_pc = pc; d2_ack = ack; d2_err = err; d2_dat = dat;
    d2_idr = idr; d2_fl = fl;
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        ack, err;
    logic [31:0] dat;
    logic        idr, fl;
    logic        e_rdy, e_val;
    logic [31:0] e_pc, e_insn;
    logic        e_err;
    logic [2:0]  e_cnt;
    logic        e_cyc;
    logic [31:0] e_adr;
  } vec_t;

  function automatic vec_t row(logic v, logic [31:0] pc, logic ack, logic err,
                               logic [31:0] dat, logic idr, logic fl, logic e_rdy,
                               logic e_val, logic [31:0] e_pc, logic [31:0] e_insn,
                               logic e_err, logic [2:0] e_cnt, logic e_cyc,
                               logic [31:0] e_adr);
    vec_t r;
    r.v = v; r.pc = pc; r.ack = ack; r.err = err; r.dat = dat; r.idr = idr; r.fl = fl;
    r.e_rdy = e_rdy; r.e_val = e_val; r.e_pc = e_pc; r.e_insn = e_insn;
    r.e_err = e_err; r.e_cnt = e_cnt; r.e_cyc = e_cyc; r.e_adr = e_adr;
    return r;
  endfunction

  // Reference model for the DEPTH=4 instance: delivered entries plus bus status.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        err;
  } ent_t;

  ent_t        mq[$];
  logic        m_busy = 1'b0;
  logic        m_want = 1'b0;
  logic [31:0] m_adr  = 32'h0;

  task automatic d4_cycle(input logic v, input logic [31:0] pc, input logic ack,
                          input logic err, input logic [31:0] dat, input logic idr,
                          input logic fl, output logic acc, output logic popd,
                          output logic [31:0] pop_pc);
    logic e_rdy, e_pop, resp;
    int   occ;
    ent_t e;
    d4_v = v; d4_pc = pc; d4_ack = ack; d4_err = err; d4_dat = dat;
    d4_idr = idr; d4_fl = fl;
    #1;
    resp  = ack | err;
    e_pop = (mq.size() > 0) && idr && !fl;
    occ   = mq.size() + ((m_busy && m_want) ? 1 : 0) - (e_pop ? 1 : 0);
    e_rdy = !fl && (occ < 4) && (!m_busy || (m_want && resp));
    chk("d4_ready", 32'(d4_rdy), 32'(e_rdy));
    chk("d4_valid", 32'(d4_val), 32'(mq.size() > 0));
    chk("d4_count", 32'(d4_cnt), 32'(mq.size()));
    chk("d4_cycstb", 32'(d4_cyc), 32'(m_busy));
    if (m_busy) chk("d4_adr", d4_adr, m_adr);
    if (mq.size() > 0) begin
      chk("d4_head_pc", d4_ipc, mq[0].pc);
      chk("d4_head_insn", d4_insn, mq[0].insn);
      chk("d4_head_err", 32'(d4_ierr), 32'(mq[0].err));
    end
    acc    = v && e_rdy;
    popd   = e_pop;
    pop_pc = d4_ipc;
    if (fl) begin
      mq.delete();
      if (m_busy && m_want) begin
        if (resp) m_busy = 1'b0;
        else m_want = 1'b0;
      end else if (m_busy && resp) begin
        m_busy = 1'b0;
      end
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_busy && resp) begin
        if (m_want) begin
          e.pc   = m_adr;
          e.insn = err ? 32'h1500_0000 : dat;
          e.err  = err;
          mq.push_back(e);
        end
        m_busy = 1'b0;
      end
      if (acc) begin
        m_busy = 1'b1;
        m_want = 1'b1;
        m_adr  = {pc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl[15];
  logic        acc, popd;
  logic [31:0] ppc;
  logic [31:0] seen[$];
  logic [31:0] nxt;
  int          nacc;
  logic        tog;

  initial begin
    d2_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    d4_v = 0; d4_pc = 0; d4_ack = 0; d4_err = 0; d4_dat = 0; d4_idr = 0; d4_fl = 0;

    tbl[0]  = row(1, 32'h100, 0, 0, 32'h0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = row(0, 32'h0, 1, 0, 32'h9C21_0004, 0, 0,  1, 0, 0, 0, 0, 0, 1, 32'h100);
    tbl[2]  = row(0, 32'h0, 0, 0, 32'h0, 1, 0,  1, 1, 32'h100, 32'h9C21_0004, 0, 1, 0, 0);
    tbl[3]  = row(1, 32'h303, 0, 0, 32'h0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = row(0, 32'h0, 1, 1, 32'hDEAD_BEEF, 0, 0,  1, 0, 0, 0, 0, 0, 1, 32'h300);
    tbl[5]  = row(0, 32'h0, 0, 0, 32'h0, 1, 0,  1, 1, 32'h300, 32'h1500_0000, 1, 1, 0, 0);
    tbl[6]  = row(1, 32'h200, 0, 0, 32'h0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = row(1, 32'h204, 1, 0, 32'hA0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 32'h200);
    tbl[8]  = row(1, 32'h208, 1, 0, 32'hA1, 0, 0,  0, 1, 32'h200, 32'hA0, 0, 1, 1, 32'h204);
    tbl[9]  = row(1, 32'h208, 0, 0, 32'h0, 0, 0,  0, 1, 32'h200, 32'hA0, 0, 2, 0, 0);
    tbl[10] = row(1, 32'h208, 0, 0, 32'h0, 1, 0,  1, 1, 32'h200, 32'hA0, 0, 2, 0, 0);
    tbl[11] = row(0, 32'h0, 1, 0, 32'hA2, 0, 0,  0, 1, 32'h204, 32'hA1, 0, 1, 1, 32'h208);
    tbl[12] = row(0, 32'h0, 0, 0, 32'h0, 1, 0,  1, 1, 32'h204, 32'hA1, 0, 2, 0, 0);
    tbl[13] = row(0, 32'h0, 0, 0, 32'h0, 1, 0,  1, 1, 32'h208, 32'hA2, 0, 1, 0, 0);
    tbl[14] = row(0, 32'h0, 0, 0, 32'h0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);

    // Reset state, with a request pending on the genpc side.
    d2_v = 1'b1;
    edge1();
    edge1();
    #1;
    chk("rst_ready", 32'(d2_rdy), 32'h0);
    chk("rst_valid", 32'(d2_val), 32'h0);
    chk("rst_cycstb", 32'(d2_cyc), 32'h0);
    chk("rst_adr", d2_adr, 32'h0);
    chk("rst_insn", d2_insn, 32'h0);
    chk("rst_pc", d2_ipc, 32'h0);
    chk("rst_err", 32'(d2_ierr), 32'h0);
    chk("rst_count", 32'(d2_cnt), 32'h0);
    rst = 1'b1;
    d2_v = 1'b0;
    edge1();

    for (int i = 0; i < 15; i++) begin
      d2_drive(tbl[i].v, tbl[i].pc, tbl[i].ack, tbl[i].err, tbl[i].dat, tbl[i].idr, tbl[i].fl);
      chk($sformatf("tbl%0d_ready", i), 32'(d2_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_valid", i), 32'(d2_val), 32'(tbl[i].e_val));
      chk($sformatf("tbl%0d_count", i), 32'(d2_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_cycstb", i), 32'(d2_cyc), 32'(tbl[i].e_cyc));
      if (tbl[i].e_cyc) chk($sformatf("tbl%0d_adr", i), d2_adr, tbl[i].e_adr);
      if (tbl[i].e_val) begin
        chk($sformatf("tbl%0d_pc", i), d2_ipc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_insn", i), d2_insn, tbl[i].e_insn);
        chk($sformatf("tbl%0d_err", i), 32'(d2_ierr), 32'(tbl[i].e_err));
      end
      edge1();
    end

    // Flush while a fetch sits in wait states and one entry is queued.
    d2_drive(1, 32'h3F0, 0, 0, 0, 0, 0); edge1();
    d2_drive(0, 0, 1, 0, 32'h1111_1111, 0, 0); edge1();
    d2_drive(1, 32'h400, 0, 0, 0, 0, 0);
    chk("fl_c0_ready", 32'(d2_rdy), 32'h1);
    chk("fl_c0_valid", 32'(d2_val), 32'h1);
    edge1();
    d2_drive(0, 0, 0, 0, 0, 0, 0);
    chk("fl_c1_ready", 32'(d2_rdy), 32'h0);
    chk("fl_c1_adr", d2_adr, 32'h400);
    edge1();
    d2_drive(1, 32'h500, 0, 0, 0, 0, 1);
    chk("fl_c2_ready", 32'(d2_rdy), 32'h0);
    chk("fl_c2_valid", 32'(d2_val), 32'h1);
    edge1();
    d2_drive(1, 32'h500, 0, 0, 0, 0, 0);
    chk("fl_c3_ready", 32'(d2_rdy), 32'h0);
    chk("fl_c3_valid", 32'(d2_val), 32'h0);
    chk("fl_c3_count", 32'(d2_cnt), 32'h0);
    chk("fl_c3_cycstb", 32'(d2_cyc), 32'h1);
    chk("fl_c3_adr", d2_adr, 32'h400);
    edge1();
    d2_drive(1, 32'h500, 1, 0, 32'h2222_2222, 0, 0);
    chk("fl_c4_ready", 32'(d2_rdy), 32'h0);
    edge1();
    d2_drive(1, 32'h500, 0, 0, 0, 0, 0);
    chk("fl_c5_ready", 32'(d2_rdy), 32'h1);
    chk("fl_c5_valid", 32'(d2_val), 32'h0);
    chk("fl_c5_cycstb", 32'(d2_cyc), 32'h0);
    edge1();
    d2_drive(0, 0, 1, 0, 32'h3333_3333, 0, 0);
    chk("fl_c6_adr", d2_adr, 32'h500);
    chk("fl_c6_valid", 32'(d2_val), 32'h0);
    edge1();
    d2_drive(0, 0, 0, 0, 0, 0, 0);
    chk("fl_c7_valid", 32'(d2_val), 32'h1);
    chk("fl_c7_pc", d2_ipc, 32'h500);
    chk("fl_c7_insn", d2_insn, 32'h3333_3333);
    chk("fl_c7_err", 32'(d2_ierr), 32'h0);
    chk("fl_c7_count", 32'(d2_cnt), 32'h1);

    // Asynchronous reset while a fetch is in flight and one entry is queued.
    d2_drive(1, 32'h504, 0, 0, 0, 0, 0);
    chk("ar_ready", 32'(d2_rdy), 32'h1);
    edge1();
    d2_drive(0, 0, 0, 0, 0, 0, 0);
    chk("ar_pre_cycstb", 32'(d2_cyc), 32'h1);
    chk("ar_pre_valid", 32'(d2_val), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_cycstb", 32'(d2_cyc), 32'h0);
    chk("ar_valid", 32'(d2_val), 32'h0);
    chk("ar_count", 32'(d2_cnt), 32'h0);
    chk("ar_ready0", 32'(d2_rdy), 32'h0);
    chk("ar_adr", d2_adr, 32'h0);
    edge1();
    rst = 1'b1;
    // Late ack from the slave after reset must be ignored.
    d2_drive(0, 0, 1, 0, 32'h4444_4444, 0, 0);
    edge1();
    d2_drive(0, 0, 0, 0, 0, 0, 0);
    chk("late_ack_valid", 32'(d2_val), 32'h0);
    chk("late_ack_count", 32'(d2_cnt), 32'h0);
    chk("late_ack_cycstb", 32'(d2_cyc), 32'h0);

    // Wrap-around on DEPTH=4: 10 sequential fetches, id_ready toggling.
    nacc = 0;
    tog  = 1'b0;
    for (int c = 0; c < 200 && seen.size() < 10; c++) begin
      d4_cycle(nacc < 10, 32'h1000 + 32'(4 * nacc), m_busy, 1'b0,
               32'hC000_0000 + 32'(c), tog, 1'b0, acc, popd, ppc);
      if (acc) nacc++;
      if (popd) seen.push_back(ppc);
      tog = ~tog;
    end
    chk("wrap_pops", 32'(seen.size()), 32'd10);
    for (int i = 0; i < seen.size(); i++)
      chk($sformatf("wrap_pc%0d", i), seen[i], 32'h1000 + 32'(4 * i));

    // Random traffic against the model.
    nxt = 32'h2000;
    for (int c = 0; c < 600; c++) begin
      logic v, ack, err, idr, fl;
      int   r;
      v   = $urandom_range(0, 3) != 0;
      idr = $urandom_range(0, 1) != 0;
      fl  = $urandom_range(0, 15) == 0;
      r   = $urandom_range(0, 7);
      if (m_busy) begin
        ack = (r < 4) || (r == 5);
        err = (r == 4) || (r == 5);
      end else begin
        ack = (r == 0);
        err = 1'b0;
      end
      d4_cycle(v, nxt | 32'($urandom_range(0, 3)), ack, err, $urandom, idr, fl,
               acc, popd, ppc);
      if (acc) nxt = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : nxt + 32'd4;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
